conv_axis_out: RTL and testbench
================================

Name: conv_axis_out

Overview:
- Receiving end of the convolution core's output stream. Accepts pxl/valid/last beats, which cannot be stalled, and buffers them in an internal FIFO.
- Re-emits the beats as an AXI-Stream master with full tready backpressure towards the DMA/S2MM path.
- Tracks frame beat count, overflow and frame completion for the AXI-Lite status registers.

Parameters:
- DATA_W, 32, pixel word width (byte 3 passthrough, bytes 2..0 = R,G,B).
- ADDR_W, 10, FIFO address width; depth = 2**ADDR_W entries.
- FRAME_BEATS, 304964, expected valid beats per frame ((480-2)*(640-2)).
- CNT_W, 20, beat counter width; must satisfy 2**CNT_W > FRAME_BEATS.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  frame enable; same signal that drives the convolution core's Start.
- pxl_in  in  DATA_W  pixel from the convolution core.
- pxl_valid  in  1  pxl_in qualifier.
- pxl_last  in  1  final pixel of frame; only meaningful with pxl_valid.
- m_axis_tdata  out  DATA_W  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tlast  out  1  stream last.
- m_axis_tready  in  1  downstream ready.
- fifo_level  out  ADDR_W+1  current FIFO occupancy.
- beat_cnt  out  CNT_W  beats accepted this frame.
- overflow  out  1  sticky: a beat was dropped.
- count_err  out  1  sticky: frame ended with beat count != FRAME_BEATS, or frame was aborted.
- frame_done  out  1  one-cycle pulse when tlast handshakes.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, FIFO empty.
  - Outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, fifo_level=0, beat_cnt=0, overflow=0, count_err=0, frame_done=0.
- FIFO entry: {last, data}, DATA_W+1 bits.
  - Write when pxl_valid=1 and state=STREAM.
  - Read when the output register is empty or is handshaking (tvalid&tready).
- Write accept rule: accepted if level<depth, or level==depth with a read in the same cycle.
  - Otherwise the beat is dropped, overflow<=1 and beat_cnt is not incremented.
  - Simultaneous read and write at any level: level unchanged.
- Output register: a beat written into an empty FIFO with the output register empty reaches m_axis_tvalid 2 cycles after the pxl_valid cycle.
  - While tvalid=1 and tready=0, tdata and tlast hold stable. tvalid never drops without a handshake.
  - Sustained throughput: 1 beat/cycle when tready=1.
- State machine:
  - IDLE: wait for start=1 (level sampled). On entry to STREAM: clear beat_cnt, overflow and count_err.
  - STREAM: accept writes. On an accepted write with pxl_last=1, go to DRAIN; count_err<=1 if beat_cnt+1 != FRAME_BEATS.
  - STREAM abort: start=0 sets count_err<=1 and goes to DRAIN. No write is accepted that cycle, and no tlast is forced.
  - DRAIN: no writes; pxl_valid is ignored and not counted as overflow. Output continues. When the FIFO and output register are both empty, go to IDLE.
  - frame_done pulses for exactly one cycle on the handshake of a beat with tlast=1, regardless of state.
- pxl_last when the FIFO is full: the beat is dropped and overflow<=1. State still goes to DRAIN with count_err<=1.
- start held high on return to IDLE: a new frame begins the next cycle, and the sticky flags clear as on any STREAM entry.
- beat_cnt saturates at 2**CNT_W-1.
- fifo_level counts FIFO entries only; it excludes the output register.

Test Plan:
- Nominal frame (FRAME_BEATS=12 override): start=1, 12 beats with tready=1, last on beat 12 → 12 beats out, tlast on the 12th only, frame_done one pulse, count_err=0, overflow=0, first tvalid 2 cycles after first pxl_valid.
- Backpressure: tready=0 for 20 cycles mid-frame, 5 beats in → fifo_level rises to 4 (one beat held in the output register) and tdata stays stable. After release, beats emerge in order with no loss.
- Overflow (ADDR_W=2, depth 4): tready=0, 7 beats in → 4 in FIFO + 1 in the output register; beats 6 and 7 dropped; overflow=1, beat_cnt=5.
- Full with simultaneous read: level=4, tready=1 and pxl_valid=1 in the same cycle → write accepted, level stays 4, overflow=0.
- Short frame / abort: pxl_last on beat 10 with FRAME_BEATS=12 → count_err=1 and frame_done still pulses. Separately, start=0 after 3 beats → 3 beats out with no tlast, state returns to IDLE, count_err=1.
- Async reset mid-DRAIN with tvalid=1 → all outputs 0 immediately; next start begins a clean frame.

Source files
------------

// File: rtl/conv_axis_out.sv
// conv_axis_out
// Receiving end of the convolution core's output stream. The core cannot be
// stalled, so its beats are buffered in a FIFO and re-emitted as an AXI-Stream
// master that honours tready. Beat count, overflow and frame-completion status
// are kept for the AXI-Lite status registers.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   start                    frame enable (level), shared with the core's Start
//   pxl_in/pxl_valid/pxl_last  incoming beat from the convolution core
//   m_axis_t*                AXI-Stream master (tdata/tvalid/tlast, tready in)
//   fifo_level               FIFO occupancy, output register excluded
//   beat_cnt                 accepted beats this frame (saturating)
//   overflow                 sticky: a beat was dropped because the FIFO was full
//   count_err                sticky: wrong frame length or aborted frame
//   frame_done               one-cycle pulse on the tlast handshake
module conv_axis_out #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int FRAME_BEATS = 304964,
  parameter int CNT_W       = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pxl_in,
  input  logic              pxl_valid,
  input  logic              pxl_last,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [ADDR_W:0]   fifo_level,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              overflow,
  output logic              count_err,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  localparam logic [ADDR_W:0]  DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   TARGET  = (CNT_W+1)'(FRAME_BEATS);

  state_t              state_q;
  logic [DATA_W:0]     mem_q [2**ADDR_W];
  logic [ADDR_W:0]     wptr_q, rptr_q;
  logic [ADDR_W:0]     level;
  logic [DATA_W-1:0]   tdata_q;
  logic                tvalid_q, tlast_q;
  logic [CNT_W-1:0]    beatCnt_q, beatCnt_d;
  logic                overflow_q, countErr_q;
  logic                rdEn, wrEn, lastOk;
  logic [DATA_W:0]     rdEntry;

  // Pointers carry one extra wrap bit so full (level==DEPTH) and empty differ.
  assign level   = wptr_q - rptr_q;
  assign rdEntry = mem_q[rptr_q[ADDR_W-1:0]];

  // Refill the output register whenever it is empty or being consumed.
  assign rdEn = (level != '0) && (!tvalid_q || m_axis_tready);

  // A full FIFO still accepts a write if a read frees a slot in the same cycle.
  // start=0 in STREAM is an abort, so no write is taken that cycle.
  assign wrEn = (state_q == STREAM) && start && pxl_valid &&
                ((level != DEPTH) || rdEn);

  assign beatCnt_d = (beatCnt_q == CNT_MAX) ? beatCnt_q : beatCnt_q + CNT_ONE;

  // Compared one bit wider so a counter at its maximum cannot wrap into a match.
  assign lastOk = (({1'b0, beatCnt_q} + {{CNT_W{1'b0}}, 1'b1}) == TARGET);

  always_ff @(posedge clk) begin
    if (wrEn) mem_q[wptr_q[ADDR_W-1:0]] <= {pxl_last, pxl_in};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      beatCnt_q  <= '0;
      overflow_q <= 1'b0;
      countErr_q <= 1'b0;
    end else begin
      if (wrEn) wptr_q <= wptr_q + PTR_ONE;

      if (rdEn) begin
        rptr_q   <= rptr_q + PTR_ONE;
        tdata_q  <= rdEntry[DATA_W-1:0];
        tlast_q  <= rdEntry[DATA_W];
        tvalid_q <= 1'b1;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= STREAM;
            beatCnt_q  <= '0;
            overflow_q <= 1'b0;
            countErr_q <= 1'b0;
          end
        end
        STREAM: begin
          if (!start) begin
            countErr_q <= 1'b1;
            state_q    <= DRAIN;
          end else if (pxl_valid) begin
            if (wrEn) beatCnt_q  <= beatCnt_d;
            else      overflow_q <= 1'b1;
            // A dropped last beat still ends the frame, necessarily short.
            if (pxl_last) begin
              state_q <= DRAIN;
              if (!wrEn || !lastOk) countErr_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if ((level == '0) && !tvalid_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign fifo_level    = level;
  assign beat_cnt      = beatCnt_q;
  assign overflow      = overflow_q;
  assign count_err     = countErr_q;
  assign frame_done    = tvalid_q & m_axis_tready & tlast_q;

endmodule

// File: tb/tb_conv_axis_out.sv
// Directed testbench for conv_axis_out with a 4-entry FIFO, 12-beat frames
// and a 4-bit beat counter so that saturation is reachable.
module tb_conv_axis_out;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;
  localparam int FRAME_BEATS = 12;
  localparam int CNT_W = 4;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [DATA_W-1:0] pxl_in;
  logic              pxl_valid;
  logic              pxl_last;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [ADDR_W:0]   fifo_level;
  logic [CNT_W-1:0]  beat_cnt;
  logic              overflow;
  logic              count_err;
  logic              frame_done;

  int checks = 0;
  int fails = 0;
  logic [DATA_W:0] outq[$];
  int fdCount = 0;

  conv_axis_out #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_BEATS(FRAME_BEATS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .pxl_in(pxl_in), .pxl_valid(pxl_valid), .pxl_last(pxl_last),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .fifo_level(fifo_level), .beat_cnt(beat_cnt), .overflow(overflow),
    .count_err(count_err), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collects every handshaken beat and every frame_done pulse.
  always @(posedge clk) begin
    if (reset_n && m_axis_tvalid && m_axis_tready) outq.push_back({m_axis_tlast, m_axis_tdata});
    if (reset_n && frame_done) fdCount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start = 1'b0;
    pxl_valid = 1'b0;
    pxl_last = 1'b0;
    pxl_in = '0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    outq.delete();
    fdCount = 0;
    tick();
  endtask

  // Drives n consecutive beats; lastAt is the 1-based beat carrying pxl_last (0 = none).
  task automatic send_beats(input int n, input int lastAt, input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      pxl_in = base + DATA_W'(i);
      pxl_valid = 1'b1;
      pxl_last = (i + 1 == lastAt);
      tick();
    end
    pxl_valid = 1'b0;
    pxl_last = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!m_axis_tvalid && fifo_level == '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b1;
    pxl_valid = 1'b1;
    pxl_last = 1'b0;
    pxl_in = 32'h1234_5678;
    m_axis_tready = 1'b1;
    #2;
    checks++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("[TB] FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_axis_tlast !== 1'b0) begin fails++; $display("[TB] FAIL reset_tlast got %b want 0", m_axis_tlast); end
    checks++; if (m_axis_tdata !== '0) begin fails++; $display("[TB] FAIL reset_tdata got %h want 0", m_axis_tdata); end
    checks++; if (fifo_level !== '0) begin fails++; $display("[TB] FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (beat_cnt !== '0) begin fails++; $display("[TB] FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (count_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_count_err got %b want 0", count_err); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_frame_done got %b want 0", frame_done); end
  endtask

  task automatic test_nominal();
    bit ok;
    int bad;
    logic [DATA_W:0] exp;
    do_reset();
    start = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      pxl_in = 32'hA000_0000 + DATA_W'(i);
      pxl_valid = 1'b1;
      pxl_last = (i == 11);
      #1;
      if (i == 1) begin
        checks++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("[TB] FAIL nominal_tvalid_early got %b want 0", m_axis_tvalid); end
      end
      if (i == 2) begin
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA000_0000) begin fails++; $display("[TB] FAIL nominal_first_beat got v=%b d=%h want v=1 d=a0000000", m_axis_tvalid, m_axis_tdata); end
      end
      @(posedge clk);
      #1;
    end
    pxl_valid = 1'b0;
    pxl_last = 1'b0;
    start = 1'b0;
    checks++; if (beat_cnt !== 4'd12) begin fails++; $display("[TB] FAIL nominal_beat_cnt got %0d want 12", beat_cnt); end
    wait_drain(ok);
    tick();
    checks++; if (!ok) begin fails++; $display("[TB] FAIL nominal_drain got timeout want drained"); end
    bad = 0;
    for (int j = 0; j < 12; j++) begin
      exp = {(j == 11), 32'hA000_0000 + DATA_W'(j)};
      if (j < outq.size()) if (outq[j] !== exp) bad++;
    end
    checks++; if (outq.size() != 12 || bad != 0) begin fails++; $display("[TB] FAIL nominal_stream got %0d beats %0d wrong want 12 beats 0 wrong", outq.size(), bad); end
    checks++; if (fdCount != 1) begin fails++; $display("[TB] FAIL nominal_frame_done got %0d pulses want 1", fdCount); end
    checks++; if (count_err !== 1'b0 || overflow !== 1'b0) begin fails++; $display("[TB] FAIL nominal_flags got ce=%b ov=%b want 0 0", count_err, overflow); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    logic [DATA_W:0] exp;
    do_reset();
    start = 1'b1;
    m_axis_tready = 1'b0;
    tick();
    send_beats(5, 0, 32'hB000_0000);
    checks++; if (fifo_level !== 3'd4) begin fails++; $display("[TB] FAIL bp_level got %0d want 4", fifo_level); end
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hB000_0000 || fifo_level !== 3'd4) bad++;
      tick();
    end
    checks++; if (bad != 0) begin fails++; $display("[TB] FAIL bp_hold_stable got %0d unstable cycles want 0", bad); end
    m_axis_tready = 1'b1;
    send_beats(7, 7, 32'hB000_0005);
    start = 1'b0;
    wait_drain(ok);
    tick();
    checks++; if (!ok) begin fails++; $display("[TB] FAIL bp_drain got timeout want drained"); end
    bad = 0;
    for (int j = 0; j < 12; j++) begin
      exp = {(j == 11), 32'hB000_0000 + DATA_W'(j)};
      if (j < outq.size()) if (outq[j] !== exp) bad++;
    end
    checks++; if (outq.size() != 12 || bad != 0) begin fails++; $display("[TB] FAIL bp_stream got %0d beats %0d wrong want 12 beats 0 wrong", outq.size(), bad); end
    checks++; if (count_err !== 1'b0 || overflow !== 1'b0 || fdCount != 1) begin fails++; $display("[TB] FAIL bp_flags got ce=%b ov=%b fd=%0d want 0 0 1", count_err, overflow, fdCount); end
  endtask

  task automatic test_overflow();
    bit ok;
    int bad;
    do_reset();
    start = 1'b1;
    m_axis_tready = 1'b0;
    tick();
    send_beats(7, 0, 32'hC000_0000);
    checks++; if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL ovf_flag got %b want 1", overflow); end
    checks++; if (beat_cnt !== 4'd5) begin fails++; $display("[TB] FAIL ovf_beat_cnt got %0d want 5", beat_cnt); end
    checks++; if (fifo_level !== 3'd4 || m_axis_tdata !== 32'hC000_0000) begin fails++; $display("[TB] FAIL ovf_fill got lvl=%0d d=%h want 4 c0000000", fifo_level, m_axis_tdata); end
    m_axis_tready = 1'b1;
    start = 1'b0;
    wait_drain(ok);
    tick();
    bad = 0;
    for (int j = 0; j < 5; j++)
      if (j < outq.size()) if (outq[j] !== {1'b0, 32'hC000_0000 + DATA_W'(j)}) bad++;
    checks++; if (!ok || outq.size() != 5 || bad != 0) begin fails++; $display("[TB] FAIL ovf_stream got ok=%0d %0d beats %0d wrong want 1 5 0", ok, outq.size(), bad); end
    checks++; if (count_err !== 1'b1 || fdCount != 0) begin fails++; $display("[TB] FAIL ovf_abort got ce=%b fd=%0d want 1 0", count_err, fdCount); end
  endtask

  task automatic test_full_simul();
    bit ok;
    int bad;
    do_reset();
    start = 1'b1;
    m_axis_tready = 1'b0;
    tick();
    send_beats(5, 0, 32'hD000_0000);
    pxl_in = 32'hD000_0005;
    pxl_valid = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    pxl_valid = 1'b0;
    m_axis_tready = 1'b0;
    checks++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin fails++; $display("[TB] FAIL full_rw_accept got lvl=%0d ov=%b want 4 0", fifo_level, overflow); end
    checks++; if (beat_cnt !== 4'd6 || m_axis_tdata !== 32'hD000_0001) begin fails++; $display("[TB] FAIL full_rw_state got cnt=%0d d=%h want 6 d0000001", beat_cnt, m_axis_tdata); end
    pxl_in = 32'hD000_0006;
    pxl_valid = 1'b1;
    tick();
    pxl_valid = 1'b0;
    checks++; if (overflow !== 1'b1 || beat_cnt !== 4'd6 || fifo_level !== 3'd4) begin fails++; $display("[TB] FAIL full_drop got ov=%b cnt=%0d lvl=%0d want 1 6 4", overflow, beat_cnt, fifo_level); end
    m_axis_tready = 1'b1;
    start = 1'b0;
    wait_drain(ok);
    tick();
    bad = 0;
    for (int j = 0; j < 6; j++)
      if (j < outq.size()) if (outq[j] !== {1'b0, 32'hD000_0000 + DATA_W'(j)}) bad++;
    checks++; if (!ok || outq.size() != 6 || bad != 0) begin fails++; $display("[TB] FAIL full_stream got ok=%0d %0d beats %0d wrong want 1 6 0", ok, outq.size(), bad); end
  endtask

  task automatic test_short_frame();
    bit ok;
    bit cleared;
    do_reset();
    start = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    send_beats(10, 10, 32'hE000_0000);
    checks++; if (count_err !== 1'b1 || beat_cnt !== 4'd10) begin fails++; $display("[TB] FAIL short_count_err got ce=%b cnt=%0d want 1 10", count_err, beat_cnt); end
    wait_drain(ok);
    tick();
    checks++; if (!ok || fdCount != 1 || outq.size() != 10) begin fails++; $display("[TB] FAIL short_done got ok=%0d fd=%0d beats=%0d want 1 1 10", ok, fdCount, outq.size()); end
    if (outq.size() == 10) begin
      checks++; if (outq[9] !== {1'b1, 32'hE000_0009}) begin fails++; $display("[TB] FAIL short_last_beat got %h want 1e0000009", outq[9]); end
    end
    cleared = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (count_err === 1'b0) begin cleared = 1'b1; break; end
      tick();
    end
    checks++; if (!cleared || beat_cnt !== '0) begin fails++; $display("[TB] FAIL short_restart got cleared=%0d cnt=%0d want 1 0", cleared, beat_cnt); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    bit ok;
    int bad;
    do_reset();
    start = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    send_beats(3, 0, 32'hF000_0000);
    start = 1'b0;
    pxl_in = 32'hF000_0003;
    pxl_valid = 1'b1;
    tick();
    pxl_valid = 1'b0;
    checks++; if (count_err !== 1'b1 || beat_cnt !== 4'd3) begin fails++; $display("[TB] FAIL abort_flags got ce=%b cnt=%0d want 1 3", count_err, beat_cnt); end
    wait_drain(ok);
    tick();
    tick();
    bad = 0;
    for (int j = 0; j < 3; j++)
      if (j < outq.size()) if (outq[j] !== {1'b0, 32'hF000_0000 + DATA_W'(j)}) bad++;
    checks++; if (!ok || outq.size() != 3 || bad != 0 || fdCount != 0) begin fails++; $display("[TB] FAIL abort_stream got ok=%0d %0d beats %0d wrong fd=%0d want 1 3 0 0", ok, outq.size(), bad, fdCount); end
    start = 1'b1;
    tick();
    checks++; if (count_err !== 1'b0) begin fails++; $display("[TB] FAIL abort_idle_restart got ce=%b want 0", count_err); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    bit ok;
    do_reset();
    start = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    send_beats(20, 0, 32'h1000_0000);
    checks++; if (beat_cnt !== 4'd15 || overflow !== 1'b0) begin fails++; $display("[TB] FAIL sat_beat_cnt got cnt=%0d ov=%b want 15 0", beat_cnt, overflow); end
    start = 1'b0;
    wait_drain(ok);
    tick();
    checks++; if (!ok || outq.size() != 20) begin fails++; $display("[TB] FAIL sat_stream got ok=%0d beats=%0d want 1 20", ok, outq.size()); end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    start = 1'b1;
    m_axis_tready = 1'b0;
    tick();
    send_beats(3, 3, 32'h2000_0000);
    checks++; if (m_axis_tvalid !== 1'b1) begin fails++; $display("[TB] FAIL arst_pre_tvalid got %b want 1", m_axis_tvalid); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, fifo_level, beat_cnt, overflow, count_err, frame_done} !== '0) begin
      fails++;
      $display("[TB] FAIL arst_outputs got v=%b l=%b d=%h lvl=%0d cnt=%0d ov=%b ce=%b fd=%b want all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, fifo_level, beat_cnt, overflow, count_err, frame_done);
    end
    reset_n = 1'b1;
    tick();
    outq.delete();
    fdCount = 0;
    m_axis_tready = 1'b1;
    tick();
    send_beats(12, 12, 32'h3000_0000);
    start = 1'b0;
    checks++; if (count_err !== 1'b0 || overflow !== 1'b0 || beat_cnt !== 4'd12) begin fails++; $display("[TB] FAIL arst_new_frame got ce=%b ov=%b cnt=%0d want 0 0 12", count_err, overflow, beat_cnt); end
    wait_drain(ok);
    tick();
    checks++; if (!ok || outq.size() != 12 || fdCount != 1) begin fails++; $display("[TB] FAIL arst_stream got ok=%0d beats=%0d fd=%0d want 1 12 1", ok, outq.size(), fdCount); end
    if (outq.size() == 12) begin
      checks++; if (outq[0] !== {1'b0, 32'h3000_0000}) begin fails++; $display("[TB] FAIL arst_first_beat got %h want 030000000", outq[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_overflow();
    test_full_simul();
    test_short_frame();
    test_abort();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
